// File: rtl/bit4_adder_core_if.sv
// Bus interface for bit4_adder_core: operand/valid inputs and registered result.
// Optional macro BIT4_ADDER_CIN_EN adds the carry-in signal Cin.
// WIDTH must match the WIDTH of the bit4_adder_core instance it connects to.
interface bit4_adder_core_if #(
    parameter int WIDTH = 4
) ();
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
`ifdef BIT4_ADDER_CIN_EN
    logic             Cin;
`endif
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             out_valid;

`ifdef BIT4_ADDER_CIN_EN
    // Producer side: drives operands, observes the registered result.
    modport master (
        output in_valid, A, B, Cin,
        input  S, Cout, out_valid
    );
    // Adder side: consumes operands, drives the registered result.
    modport slave (
        input  in_valid, A, B, Cin,
        output S, Cout, out_valid
    );
`else
    // Producer side: drives operands, observes the registered result.
    modport master (
        output in_valid, A, B,
        input  S, Cout, out_valid
    );
    // Adder side: consumes operands, drives the registered result.
    modport slave (
        input  in_valid, A, B,
        output S, Cout, out_valid
    );
`endif
endinterface

// File: rtl/bit4_adder_core.sv
// bit4_adder_core: registered unsigned ripple-carry adder.
// A chain of WIDTH full-adder cells produces {c_out, sum} = A + B + cin,
// captured into the output register when in_valid is high (1-cycle latency).
// Optional macro BIT4_ADDER_CIN_EN: when defined, bus.Cin drives the carry
// into cell 0; otherwise the carry-in is tied to zero (plain A+B adder).
// WIDTH legal range is 1..32.
module bit4_adder_core #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    bit4_adder_core_if.slave   bus
);

    logic             cin_s;
    logic [WIDTH-1:0] sum_s;
    logic             c_out_s;

    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] s_d;
    logic             cout_q;
    logic             cout_d;
    logic             out_valid_q;
    logic             out_valid_d;

`ifdef BIT4_ADDER_CIN_EN
    assign cin_s = bus.Cin;
`else
    assign cin_s = 1'b0;
`endif

    // Ripple chain: each cell keeps its own carry signals so the chain is a
    // set of distinct nets rather than one self-referencing vector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic a_s;
        logic b_s;
        logic c_in_s;
        logic s_s;
        logic c_nxt_s;

        assign a_s = bus.A[i];
        assign b_s = bus.B[i];

        if (i == 0) begin : g_first
            assign c_in_s = cin_s;
        end else begin : g_next
            assign c_in_s = g_fa[i-1].c_nxt_s;
        end

        assign s_s     = a_s ^ b_s ^ c_in_s;
        assign c_nxt_s = (a_s & b_s) | (c_in_s & (a_s ^ b_s));
        assign sum_s[i] = s_s;
    end

    assign c_out_s = g_fa[WIDTH-1].c_nxt_s;

    // Next-state: capture the sum on a valid cycle, otherwise hold result and drop valid.
    always_comb begin
        s_d         = s_q;
        cout_d      = cout_q;
        out_valid_d = 1'b0;
        if (bus.in_valid) begin
            s_d         = sum_s;
            cout_d      = c_out_s;
            out_valid_d = 1'b1;
        end else begin
            s_d         = s_q;
            cout_d      = cout_q;
            out_valid_d = 1'b0;
        end
    end

    // Output register stage; asynchronous reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= {WIDTH{1'b0}};
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.S         = s_q;
    assign bus.Cout      = cout_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_bit4_adder_core.sv
// Scoreboard bench for bit4_adder_core (WIDTH=4). Stimulus pushes expected
// {Cout,S} values into a queue; a monitor pops and compares whenever
// out_valid is seen. Define BIT4_ADDER_CIN_EN to also exercise Cin.
module tb_bit4_adder_core;

    localparam int W = 4;

    logic clk;
    logic rst_n;

    bit4_adder_core_if #(.WIDTH(W)) bus_if ();

    bit4_adder_core #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    logic [W:0] exp_q[$];
    int total;
    int bad;
    int pops;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: every presented result must match the oldest expectation.
    initial begin
        logic [W:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus_if.out_valid === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_result: got {Cout,S}=%0d expected no output at %0t",
                             {bus_if.Cout, bus_if.S}, $time);
                end else begin
                    e = exp_q.pop_front();
                    pops++;
                    if ({bus_if.Cout, bus_if.S} !== e) begin
                        bad++;
                        $display("FAIL result: got {Cout,S}=%0d expected %0d at %0t",
                                 {bus_if.Cout, bus_if.S}, e, $time);
                    end
                end
            end
        end
    end

    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W:0] expv);
        @(posedge clk);
        #2;
        bus_if.in_valid = v;
        bus_if.A        = a;
        bus_if.B        = b;
`ifdef BIT4_ADDER_CIN_EN
        bus_if.Cin      = 1'b0;
`endif
        if (v) exp_q.push_back(expv);
    endtask

`ifdef BIT4_ADDER_CIN_EN
    task automatic step_c(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W:0] expv);
        @(posedge clk);
        #2;
        bus_if.in_valid = 1'b1;
        bus_if.A        = a;
        bus_if.B        = b;
        bus_if.Cin      = c;
        exp_q.push_back(expv);
    endtask
`endif

    task automatic chk_zero(input string tag);
        chk({tag, "_S"},         32'(bus_if.S),         32'd0);
        chk({tag, "_Cout"},      32'(bus_if.Cout),      32'd0);
        chk({tag, "_out_valid"}, 32'(bus_if.out_valid), 32'd0);
    endtask

    initial begin
        int pops_before;
        total = 0;
        bad   = 0;
        pops  = 0;

        // Reset held with live valid inputs: outputs must stay cleared.
        rst_n           = 1'b0;
        bus_if.in_valid = 1'b1;
        bus_if.A        = 4'd9;
        bus_if.B        = 4'd12;
`ifdef BIT4_ADDER_CIN_EN
        bus_if.Cin      = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk_zero("reset");
        end

        // Release and first capture: 3+4 = 7.
        @(posedge clk);
        #2;
        rst_n    = 1'b1;
        bus_if.A = 4'd3;
        bus_if.B = 4'd4;
        exp_q.push_back(5'd7);

        // Sweep with hand-computed results.
        step(1'b1, 4'd0,  4'd5, 5'd5);
        step(1'b1, 4'd9,  4'd2, 5'd11);
        step(1'b0, 4'd1,  4'd1, 5'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("hold_S",         32'(bus_if.S),         32'd11);
        chk("hold_Cout",      32'(bus_if.Cout),      32'd0);
        chk("hold_out_valid", 32'(bus_if.out_valid), 32'd0);
        step(1'b1, 4'd10, 4'd10, 5'd20);
        step(1'b1, 4'd15, 4'd15, 5'd30);
        step(1'b0, 4'd0,  4'd0,  5'd0);
        @(negedge clk);
        #1;
        chk("drain_before_midop", 32'(exp_q.size()), 32'd0);

        // Reset between edges while a valid capture is pending.
        step(1'b1, 4'd10, 4'd10, 5'd20);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk_zero("midop_async");
        exp_q.delete();
        @(posedge clk);
        #2;
        rst_n           = 1'b1;
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk_zero("midop_after_release");
        step(1'b1, 4'd6, 4'd7, 5'd13);

        // Exhaustive back-to-back sweep.
        pops_before = pops;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                step(1'b1, 4'(a), 4'(b), 5'(a) + 5'(b));
            end
        end
        step(1'b0, 4'd0, 4'd0, 5'd0);
        @(negedge clk);
        #1;
        chk("exhaustive_count", 32'(pops - pops_before), 32'd257);

`ifdef BIT4_ADDER_CIN_EN
        step_c(4'd15, 4'd0, 1'b1, 5'd16);
        step_c(4'd7,  4'd8, 1'b1, 5'd16);
        step_c(4'd7,  4'd8, 1'b0, 5'd15);
        step(1'b0, 4'd0, 4'd0, 5'd0);
        @(negedge clk);
        #1;
`endif

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bit4_adder_core.md
Name: bit4_adder_core

Overview:
- Registered unsigned ripple-carry adder, default 4-bit operands, producing a sum and a carry-out.
- The combined result {Cout,S} is WIDTH+1 bits.
- Used as a small arithmetic leaf in datapaths that need a registered sum plus a valid strobe.
- Core is a chain of WIDTH full-adder cells (generate loop) feeding an output register stage.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A/B (and Cin when enabled) are valid this cycle.
- A  input  WIDTH  unsigned operand A.
- B  input  WIDTH  unsigned operand B.
- S  output  WIDTH  registered sum bits [WIDTH-1:0].
- Cout  output  1  registered carry-out; MSB of the WIDTH+1-bit result.
- out_valid  output  1  S/Cout hold a new result this cycle.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). While rst_n=0: S=0, Cout=0, out_valid=0, independent of clk. Release is synchronised by the implementation's normal flop behaviour; first capture is on the first rising edge with rst_n=1.
- Arithmetic:
  - Combinational {c_out, sum} = A + B + cin, computed as an explicit ripple chain.
  - Cell i: s_i = a_i ^ b_i ^ c_i; c_(i+1) = a_i&b_i | c_i&(a_i^b_i); c_0 = cin.
  - cin = 0 unless the optional feature is enabled.
- Latency: exactly 1 cycle. On a rising edge with in_valid=1:
  - S <= sum; Cout <= c_out; out_valid <= 1.
- Hold: on a rising edge with in_valid=0:
  - S and Cout hold their previous values; out_valid <= 0.
- Throughput: one result per cycle; no backpressure, no ready signal.
- Overflow: no saturation. Results >= 2^WIDTH appear as Cout=1 with S = (A+B) mod 2^WIDTH. Max case A=B=2^WIDTH-1 gives Cout=1, S=2^WIDTH-2.
- X-safety: A/B are ignored when in_valid=0. No X may reach the outputs after reset unless captured inputs are X.
- Reset mid-operation: asserting rst_n=0 while in_valid=1 clears the outputs immediately. The in-flight result is discarded and never presented.

Optional Feature:
- Macro BIT4_ADDER_CIN_EN.
- Defined:
  - Adds input port Cin (1 bit) after B; it drives c_0.
  - Result = A + B + Cin, captured under in_valid like A/B.
  - Example: A=15, B=0, Cin=1 -> S=0, Cout=1.
- Not defined:
  - Port Cin absent; c_0 tied to 0.
  - Behaviour identical to a plain A+B adder.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with arbitrary A/B and in_valid=1 -> S=0, Cout=0, out_valid=0 throughout; deassert, apply A=3, B=4, in_valid=1 -> next edge S=7, Cout=0, out_valid=1.
- Sweep WIDTH=4, in_valid=1, one per cycle, results one cycle later:
  - 0+5 -> S=5, Cout=0.
  - 9+2 -> S=11, Cout=0.
  - 10+10 -> S=4, Cout=1.
  - 15+15 -> S=14, Cout=1.
- Hold: after 9+2, drop in_valid and change A=1, B=1 -> S stays 11, Cout 0, out_valid=0.
- Mid-op reset: A=10, B=10, in_valid=1, pulse rst_n low between edges -> outputs 0 immediately and stay 0 until the next valid capture after release.
- Exhaustive: all 256 A/B pairs back-to-back -> each {Cout,S} equals A+B one cycle later, out_valid=1 continuously.
- With BIT4_ADDER_CIN_EN:
  - A=15, B=0, Cin=1 -> S=0, Cout=1.
  - A=7, B=8, Cin=1 -> S=0, Cout=1.
  - A=7, B=8, Cin=0 -> S=15, Cout=0.
